inst_fetch: RTL and testbench

Instruction fetch front-end sitting directly upstream of the uncached instruction bus slave. It generates the PC sequence and issues single-word requests over the `inst_bus` handshake. It absorbs redirects by dropping stale responses, then queues `{pc, inst, error flags}` entries in a small FIFO for the decode stage. Straight-line fetch runs with one request outstanding and issues back-to-back on the response cycle.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/inst_bus.sv | 21 ++
 rtl/fetch_queue.sv | 82 ++++++++
 rtl/inst_fetch.sv | 148 ++++++++++++++
 tb/tb_inst_fetch.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
//   fetch_entry_t    : one decoded-stage queue entry {pc, inst, acc_err, misaligned}
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_STEP          : PC increment for straight-line fetch (one 32-bit word)
package fetch_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PC_STEP          = 64'd4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        acc_err;
        logic        misaligned;
    } fetch_entry_t;

    // A fetch address is only legal on a 32-bit word boundary.
    function automatic logic pc_misaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_bus.sv
// Single-word instruction bus between the fetch unit (master) and the
// uncached instruction slave.
//   en      : master -> slave, request strobe (addr valid)
//   addr    : master -> slave, 64-bit word address
//   ready   : master -> slave, master accepts a response this cycle
//   valid   : slave -> master, response strobe
//   rdata   : slave -> master, 32-bit instruction word
//   acc_err : slave -> master, access fault for this response
interface inst_bus;
    logic        en;
    logic [63:0] addr;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
    logic        acc_err;

    modport master (output en, output addr, output ready,
                    input  valid, input rdata, input acc_err);
    modport slave  (input  en, input addr, input ready,
                    output valid, output rdata, output acc_err);
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH-entry FIFO of fetch_entry_t with synchronous flush.
//   clk_i       : clock (rising edge)
//   rst_ni      : asynchronous active-low reset (pointers and count only)
//   push_i      : enqueue push_data_i (accepted when not full, or full with pop)
//   push_data_i : entry to enqueue
//   pop_i       : dequeue request (ignored when empty)
//   flush_i     : drop all entries; wins over push and pop
//   head_o      : head entry, all-zero when empty
//   valid_o     : queue holds at least one entry
//   count_o     : number of entries held (0..DEPTH)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front-end. Generates the sequential PC stream, issues
// one outstanding single-word request at a time on ibus, drops responses
// made stale by a redirect and queues {pc, inst, acc_err, misaligned}
// entries for decode.
//   clock          : clock (rising edge)
//   reset_n        : asynchronous active-low reset
//   ibus           : inst_bus master (en/addr/ready out, valid/rdata/acc_err in)
//   redirect_valid : flush the queue and restart fetch at redirect_pc
//   redirect_pc    : new fetch PC
//   out_valid      : queue head valid
//   out_ready      : decode accepts the head entry
//   out_pc         : PC of head entry
//   out_inst       : instruction word (0 for misaligned entries)
//   out_acc_err    : bus access fault for this PC
//   out_misaligned : PC not word aligned; no bus access was made
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    inst_bus.master     ibus,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_acc_err,
    output logic        out_misaligned
);

    localparam int             CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]    DEPTH_OCC = (CW + 1)'(DEPTH);

    logic [63:0]   pc_q, pc_d;
    logic [63:0]   req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          drop_q, drop_d;
    logic          halted_q, halted_d;

    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          resp, bus_free, issue_ok;
    logic          resp_enq, mis_enq, push;
    fetch_entry_t  push_data, head;

    // A response only counts while a request is actually in flight.
    assign resp      = ibus.valid && outstanding_q;
    assign bus_free  = !outstanding_q || resp;
    // Reserve a queue slot for every in-flight request so a response can
    // always be enqueued the cycle it arrives.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding_q};
    assign issue_ok  = bus_free && (occupancy < DEPTH_OCC) && !halted_q &&
                       !redirect_valid && !pc_misaligned(pc_q);

    assign ibus.en    = issue_ok && reset_n;
    assign ibus.addr  = pc_q;
    assign ibus.ready = outstanding_q;

    assign resp_enq = resp && !drop_q && !redirect_valid;
    // Misaligned entries bypass the bus; they wait for any in-flight
    // (necessarily dropped) response to drain first.
    assign mis_enq  = pc_misaligned(pc_q) && !halted_q && !outstanding_q &&
                      (count < CW'(DEPTH)) && !redirect_valid;
    assign push     = resp_enq || mis_enq;

    always_comb begin
        push_data = '0;
        if (mis_enq) begin
            push_data.pc         = pc_q;
            push_data.misaligned = 1'b1;
        end else begin
            push_data.pc      = req_pc_q;
            push_data.inst    = ibus.rdata;
            push_data.acc_err = ibus.acc_err;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        halted_d      = halted_q;

        if (issue_ok) begin
            req_pc_d      = pc_q;
            pc_d          = pc_q + PC_STEP;
            outstanding_d = 1'b1;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        if (resp) drop_d = 1'b0;
        if (resp_enq && ibus.acc_err) halted_d = 1'b1;
        if (mis_enq) halted_d = 1'b1;

        // Redirect overrides the PC and halt state; a request still in
        // flight without its response this cycle must be discarded later.
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            if (outstanding_q && !resp) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halted_q      <= halted_d;
        end
    end

    // req_pc is only read alongside a response, which needs a prior issue.
    always_ff @(posedge clock) begin
        req_pc_q <= req_pc_d;
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (out_ready),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .valid_o     (out_valid),
        .count_o     (count)
    );

    assign out_pc         = head.pc;
    assign out_inst       = head.inst;
    assign out_acc_err    = head.acc_err;
    assign out_misaligned = head.misaligned;

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
module tb_inst_fetch;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] RDIR  = 64'h0000_0000_8000_1000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_acc_err, out_misaligned;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    inst_bus ibus ();

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ibus           (ibus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_acc_err    (out_acc_err),
        .out_misaligned (out_misaligned)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // bus slave model
    bit          sl_busy, sl_stale;
    logic [63:0] sl_addr;
    int          sl_wait;
    int          lat_min = 2, lat_max = 2;
    bit          inst_const;
    bit          rand_err;
    logic [63:0] err_addr = '1;

    // reference model: next request address, next entry address, halt state
    logic [63:0] exp_req, exp_ent;
    bit          exp_halt, exp_stop;

    // observations
    bit          obs_en, obs_ovalid;
    logic [63:0] obs_addr;
    int          en_count, deq_count, stale_acc, cyc, first_deq_cyc;
    bit          chk_en_on_valid;
    logic [63:0] deq_pcs[$];
    bit          deq_errs[$];
    logic [63:0] last_pc;
    logic [31:0] last_inst;
    bit          last_err, last_mis;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (inst_const) return 32'h0000_0013;
        return a[31:0] ^ 32'h5a5a_0f0f ^ {a[15:0], a[47:32]};
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        return (a == err_addr) || (rand_err && a[8:2] == 7'h55);
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, advance model.
    task automatic step(input bit rdy, input bit rdir = 1'b0, input logic [63:0] rpc = 64'h0);
        logic        rsp, want_mis, want_err;
        logic [31:0] want_inst;
        rsp            = sl_busy && (sl_wait == 0);
        ibus.valid     = rsp;
        ibus.rdata     = rsp ? mem_word(sl_addr) : 32'h0;
        ibus.acc_err   = rsp ? mem_err(sl_addr) : 1'b0;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        obs_en     = (ibus.en === 1'b1);
        obs_addr   = ibus.addr;
        obs_ovalid = (out_valid === 1'b1);

        checks++;
        if (ibus.ready !== sl_busy) begin
            errors++;
            $display("FAIL ready: got %b want %b (cycle %0d)", ibus.ready, sl_busy, cyc);
        end
        if (rsp && sl_stale && ibus.ready === 1'b1) stale_acc++;

        if (obs_en) begin
            en_count++;
            checks++;
            if (rdir || exp_halt || (sl_busy && !rsp) || exp_req[1:0] != 2'b00) begin
                errors++;
                $display("FAIL issue_allowed: en=1 addr=%h redirect=%b halted=%b busy=%b", obs_addr, rdir, exp_halt, sl_busy);
            end
            checks++;
            if (obs_addr !== exp_req) begin
                errors++;
                $display("FAIL issue_addr: got %h want %h", obs_addr, exp_req);
            end
        end
        if (chk_en_on_valid && rsp) begin
            checks++;
            if (!obs_en) begin
                errors++;
                $display("FAIL en_on_valid: got 0 want 1 (cycle %0d)", cyc);
            end
        end

        checks++;
        if (obs_ovalid) begin
            if (rdy) begin
                want_mis  = (exp_ent[1:0] != 2'b00);
                want_inst = want_mis ? 32'h0 : mem_word(exp_ent);
                want_err  = want_mis ? 1'b0 : mem_err(exp_ent);
                if (exp_stop || out_pc !== exp_ent || out_inst !== want_inst ||
                    out_acc_err !== want_err || out_misaligned !== want_mis) begin
                    errors++;
                    $display("FAIL entry: got pc=%h inst=%h err=%b mis=%b want pc=%h inst=%h err=%b mis=%b stopped=%b",
                             out_pc, out_inst, out_acc_err, out_misaligned, exp_ent, want_inst, want_err, want_mis, exp_stop);
                end
                deq_count++;
                deq_pcs.push_back(out_pc);
                deq_errs.push_back(out_acc_err);
                last_pc = out_pc; last_inst = out_inst; last_err = out_acc_err; last_mis = out_misaligned;
                if (first_deq_cyc < 0) first_deq_cyc = cyc;
                exp_ent = exp_ent + 64'd4;
                if (want_mis) exp_stop = 1'b1;
            end
        end else if ({out_pc, out_inst, out_acc_err, out_misaligned} !== '0) begin
            errors++;
            $display("FAIL empty_payload: got pc=%h inst=%h err=%b mis=%b want all zero",
                     out_pc, out_inst, out_acc_err, out_misaligned);
        end

        if (rsp) begin
            if (!sl_stale && !rdir && mem_err(sl_addr)) exp_halt = 1'b1;
            sl_busy  = 1'b0;
            sl_stale = 1'b0;
        end else if (sl_busy && sl_wait > 0) begin
            sl_wait--;
        end
        if (rdir) begin
            if (sl_busy) sl_stale = 1'b1;
            exp_req  = rpc;
            exp_ent  = rpc;
            exp_halt = 1'b0;
            exp_stop = 1'b0;
        end
        if (obs_en) begin
            sl_busy  = 1'b1;
            sl_stale = 1'b0;
            sl_addr  = obs_addr;
            sl_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
            exp_req  = exp_req + 64'd4;
        end
        cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        ibus.valid = 1'b0; ibus.rdata = '0; ibus.acc_err = 1'b0;
        sl_busy = 1'b0; sl_stale = 1'b0; sl_wait = 0;
        exp_req = RPC; exp_ent = RPC; exp_halt = 1'b0; exp_stop = 1'b0;
        en_count = 0; deq_count = 0; stale_acc = 0; cyc = 0; first_deq_cyc = -1;
        chk_en_on_valid = 1'b0;
        deq_pcs.delete(); deq_errs.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if (ibus.en !== 1'b0)   begin errors++; $display("FAIL reset_en: got %b want 0", ibus.en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (ibus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ibus.ready); end
        checks++; if (out_pc !== 64'h0)   begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        reset_n = 1'b1;
        step(1'b0);
        checks++;
        if (!obs_en || obs_addr !== RPC) begin
            errors++;
            $display("FAIL reset_first_req: got en=%b addr=%h want en=1 addr=%h", obs_en, obs_addr, RPC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        inst_const = 1'b1; lat_min = 2; lat_max = 2; chk_en_on_valid = 1'b1;
        for (int i = 0; i < 40 && deq_count < 3; i++) step(1'b1);
        chk_en_on_valid = 1'b0;
        checks++;
        if (deq_count < 3) begin
            errors++; $display("FAIL stream_timeout: got %0d entries want 3", deq_count);
        end else begin
            checks++;
            if (deq_pcs[0] !== RPC || deq_pcs[1] !== RPC + 64'd4 || deq_pcs[2] !== RPC + 64'd8) begin
                errors++;
                $display("FAIL stream_order: got %h %h %h want %h %h %h", deq_pcs[0], deq_pcs[1], deq_pcs[2],
                         RPC, RPC + 64'd4, RPC + 64'd8);
            end
        end
        checks++;
        if (first_deq_cyc != 3) begin
            errors++; $display("FAIL stream_latency: got first entry at cycle %0d want 3", first_deq_cyc);
        end
        inst_const = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 2; lat_max = 4;
        repeat (40) step(1'b0);
        checks++;
        if (en_count != DEPTH) begin
            errors++; $display("FAIL bp_requests: got %0d want %0d", en_count, DEPTH);
        end
        checks++;
        if (!obs_ovalid) begin
            errors++; $display("FAIL bp_out_valid: got 0 want 1");
        end
        en_count = 0;
        step(1'b1);
        repeat (40) step(1'b0);
        checks++;
        if (en_count != 1 || deq_count != 1) begin
            errors++; $display("FAIL bp_one_more: got %0d requests %0d dequeues want 1 1", en_count, deq_count);
        end
    endtask

    task automatic test_redirect_inflight();
        bit found = 1'b0;
        do_reset();
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1);
            if (obs_en && obs_addr == RPC + 64'd8) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL inflight_timeout: request to %h never seen", RPC + 64'd8); end
        step(1'b1, 1'b1, RDIR);
        deq_pcs.delete();
        step(1'b1);
        checks++;
        if (obs_ovalid) begin errors++; $display("FAIL inflight_flush: got out_valid 1 want 0"); end
        for (int i = 0; i < 40 && deq_pcs.size() == 0; i++) step(1'b1);
        checks++;
        if (deq_pcs.size() == 0 || deq_pcs[0] !== RDIR) begin
            errors++; $display("FAIL inflight_next_pc: got %h want %h", (deq_pcs.size() != 0) ? deq_pcs[0] : 64'h0, RDIR);
        end
        checks++;
        if (stale_acc != 1) begin errors++; $display("FAIL inflight_drop_accept: got %0d want 1", stale_acc); end
    endtask

    task automatic test_redirect_valid_cycle();
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(sl_busy && sl_wait == 0); i++) step(1'b1);
        checks++;
        if (!(sl_busy && sl_wait == 0)) begin errors++; $display("FAIL rvc_timeout: no response due"); end
        step(1'b1, 1'b1, RDIR);
        deq_pcs.delete();
        checks++;
        if (obs_en) begin errors++; $display("FAIL rvc_en_redirect: got 1 want 0"); end
        step(1'b1);
        checks++;
        if (!obs_en || obs_addr !== RDIR) begin
            errors++; $display("FAIL rvc_next_req: got en=%b addr=%h want en=1 addr=%h", obs_en, obs_addr, RDIR);
        end
        for (int i = 0; i < 20 && deq_pcs.size() == 0; i++) step(1'b1);
        checks++;
        if (deq_pcs.size() == 0 || deq_pcs[0] !== RDIR) begin
            errors++; $display("FAIL rvc_next_pc: got %h want %h", (deq_pcs.size() != 0) ? deq_pcs[0] : 64'h0, RDIR);
        end
    endtask

    task automatic test_access_fault();
        bit seen = 1'b0;
        do_reset();
        err_addr = RPC + 64'd4; lat_min = 2; lat_max = 2;
        repeat (40) step(1'b1);
        foreach (deq_pcs[i]) if (deq_pcs[i] == RPC + 64'd4 && deq_errs[i]) seen = 1'b1;
        checks++;
        if (!seen) begin errors++; $display("FAIL fault_entry: no entry at %h with acc_err=1", RPC + 64'd4); end
        checks++;
        if (en_count != 3) begin errors++; $display("FAIL fault_requests: got %0d want 3", en_count); end
        en_count = 0;
        step(1'b1, 1'b1, RPC + 64'h40);
        repeat (10) step(1'b1);
        checks++;
        if (en_count == 0) begin errors++; $display("FAIL fault_resume: got 0 requests after redirect want >0"); end
        err_addr = '1;
    endtask

    task automatic test_misaligned();
        do_reset();
        lat_min = 2; lat_max = 2;
        step(1'b0, 1'b1, RPC + 64'd2);
        checks++;
        if (obs_en) begin errors++; $display("FAIL mis_en_redirect: got 1 want 0"); end
        repeat (6) step(1'b0);
        step(1'b1);
        checks++;
        if (deq_count != 1 || last_pc !== RPC + 64'd2 || !last_mis || last_inst !== 32'h0 || last_err) begin
            errors++;
            $display("FAIL mis_entry: got n=%0d pc=%h mis=%b inst=%h err=%b want n=1 pc=%h mis=1 inst=0 err=0",
                     deq_count, last_pc, last_mis, last_inst, last_err, RPC + 64'd2);
        end
        repeat (6) step(1'b1);
        checks++;
        if (en_count != 0) begin errors++; $display("FAIL mis_no_request: got %0d want 0", en_count); end
        // reset while a request is in flight and the queue holds entries
        step(1'b0, 1'b1, RPC);
        repeat (5) step(1'b0);
        checks++;
        if (!sl_busy || !obs_ovalid) begin errors++; $display("FAIL mis_setup: busy=%b out_valid=%b want 1 1", sl_busy, obs_ovalid); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ibus.en !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got en=%b out_valid=%b want 0 0", ibus.en, out_valid);
        end
        do_reset();
    endtask

    task automatic test_random();
        int ndeq;
        logic [63:0] rpc;
        do_reset();
        lat_min = 2; lat_max = 5; rand_err = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                rpc = RPC + 64'($urandom_range(0, 255) * 4);
                if ($urandom_range(0, 7) == 0) rpc = rpc + 64'd2;
                step($urandom_range(0, 9) < 7, 1'b1, rpc);
            end else begin
                step($urandom_range(0, 9) < 7);
            end
        end
        ndeq = deq_count;
        checks++;
        if (ndeq < 100) begin errors++; $display("FAIL random_progress: got %0d entries want >=100", ndeq); end
        rand_err = 1'b0;
    endtask

    initial begin
        ibus.valid = 1'b0; ibus.rdata = '0; ibus.acc_err = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_valid_cycle();
        test_access_fault();
        test_misaligned();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
